// File: rtl/dlfloat_link_master.sv
// Host-side link master for the DLFloat16 MAC pad interface.
// TX drives operand pairs onto the 16-bit pad bus as A (phase 0) then B (phase 1).
// RX reassembles byte-serial results, keeps tagged words, and buffers them in a FIFO.
// Optional feature macro: DLF_LINK_NAN_FLAG_EN adds res_nan / nan_seen outputs.
module dlfloat_link_master #(
  parameter int unsigned LAT_PAIRS  = 3,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        op_valid,
  output logic        op_ready,
  input  logic [15:0] op_a,
  input  logic [15:0] op_b,
  output logic [15:0] pad_out,
  input  logic [7:0]  pad_in,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [15:0] res_data,
  output logic        busy
`ifdef DLF_LINK_NAN_FLAG_EN
  ,
  output logic        res_nan,
  output logic        nan_seen
`endif
);

  localparam int unsigned DW    = 16;
  localparam int unsigned BW    = 8;
  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  logic             phase_q,     phase_d;
  logic [DW-1:0]    pad_q,       pad_d;
  logic [DW-1:0]    b_hold_q,    b_hold_d;
  logic [BW-1:0]    hi_q,        hi_d;
  logic [LAT_PAIRS-1:0] tag_q,   tag_d;
  logic [CNT_W-1:0] inflight_q,  inflight_d;
  logic [CNT_W-1:0] count_q,     count_d;
  logic [PTR_W-1:0] rd_q,        rd_d;
  logic [PTR_W-1:0] wr_q,        wr_d;
  logic [DW-1:0]    mem_q [FIFO_DEPTH];
  logic [DW-1:0]    mem_d [FIFO_DEPTH];
  logic             op_ready_q,  op_ready_d;
  logic             res_valid_q, res_valid_d;
  logic [DW-1:0]    res_data_q,  res_data_d;
  logic             busy_q,      busy_d;
`ifdef DLF_LINK_NAN_FLAG_EN
  logic             res_nan_q,   res_nan_d;
  logic             nan_seen_q,  nan_seen_d;
`endif

  logic          accept_c;
  logic          push_c;
  logic          pop_c;
  logic [DW-1:0] word_c;

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase_q     <= 1'b0;
      pad_q       <= '0;
      b_hold_q    <= '0;
      hi_q        <= '0;
      tag_q       <= '0;
      inflight_q  <= '0;
      count_q     <= '0;
      rd_q        <= '0;
      wr_q        <= '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= '0;
      op_ready_q  <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      busy_q      <= 1'b0;
`ifdef DLF_LINK_NAN_FLAG_EN
      res_nan_q   <= 1'b0;
      nan_seen_q  <= 1'b0;
`endif
    end else begin
      phase_q     <= phase_d;
      pad_q       <= pad_d;
      b_hold_q    <= b_hold_d;
      hi_q        <= hi_d;
      tag_q       <= tag_d;
      inflight_q  <= inflight_d;
      count_q     <= count_d;
      rd_q        <= rd_d;
      wr_q        <= wr_d;
      mem_q       <= mem_d;
      op_ready_q  <= op_ready_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      busy_q      <= busy_d;
`ifdef DLF_LINK_NAN_FLAG_EN
      res_nan_q   <= res_nan_d;
      nan_seen_q  <= nan_seen_d;
`endif
    end
  end

  // Slot sequencing, RX capture, tag pipeline, credits and result FIFO next state.
  always_comb begin
    phase_d    = ~phase_q;
    pad_d      = '0;
    b_hold_d   = b_hold_q;
    hi_d       = hi_q;
    tag_d      = tag_q;
    inflight_d = inflight_q;
    count_d    = count_q;
    rd_d       = rd_q;
    wr_d       = wr_q;
    mem_d      = mem_q;
`ifdef DLF_LINK_NAN_FLAG_EN
    nan_seen_d = nan_seen_q;
`endif

    accept_c = phase_q & op_valid & op_ready_q;
    word_c   = {hi_q, pad_in};
    push_c   = ~phase_q & tag_q[LAT_PAIRS-1];
    pop_c    = res_valid_q & res_ready;

    if (phase_q) begin
      // Phase 1 edge: latch high byte, optionally launch A into the phase-0 slot.
      hi_d = pad_in;
      if (accept_c) begin
        pad_d      = op_a;
        b_hold_d   = op_b;
        tag_d[0]   = 1'b1;
        inflight_d = inflight_q + CNT_W'(1);
      end
    end else begin
      // Phase 0 edge: B follows only if the preceding phase-1 edge accepted.
      pad_d = tag_q[0] ? b_hold_q : '0;
      tag_d = tag_q << 1;
      if (push_c) begin
        inflight_d = inflight_q - CNT_W'(1);
      end
    end

    if (pop_c) begin
      rd_d = rd_q + PTR_W'(1);
    end
    if (push_c) begin
      mem_d[wr_q] = word_c;
      wr_d        = wr_q + PTR_W'(1);
`ifdef DLF_LINK_NAN_FLAG_EN
      if (word_c == 16'hFFFF) nan_seen_d = 1'b1;
`endif
    end

    case ({push_c, pop_c})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    op_ready_d  = phase_d & (CNT_W'(inflight_d + count_d) < CNT_W'(FIFO_DEPTH));
    res_valid_d = (count_d != '0);
    res_data_d  = mem_d[rd_d];
    busy_d      = (inflight_d != '0) | (count_d != '0);
`ifdef DLF_LINK_NAN_FLAG_EN
    res_nan_d   = (count_d != '0) & (res_data_d == 16'hFFFF);
`endif
  end

  assign op_ready  = op_ready_q;
  assign pad_out   = pad_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign busy      = busy_q;
`ifdef DLF_LINK_NAN_FLAG_EN
  assign res_nan   = res_nan_q;
  assign nan_seen  = nan_seen_q;
`endif

endmodule

// File: doc/dlfloat_link_master.md
Name: dlfloat_link_master

Overview:
- Host-side counterpart of the DLFloat16 MAC pad interface.
- TX side: takes operand pairs on a valid/ready stream and drives them onto the 16-bit operand pad bus {uio_in,ui_in} in the two-slot pattern A then B.
- RX side: collects the byte-serialized accumulator result (uo_out, high byte then low byte), reassembles 16-bit words, tags the words that belong to issued operations, and buffers them in a result FIFO with valid/ready output.
- Shares clk and rst_n with the MAC, so slot phase is aligned by reset.

Parameters:
- LAT_PAIRS, 3: number of phase-0 edges from operand accept to completion of the matching result word (1..8).
- FIFO_DEPTH, 4: result FIFO entries, power of two, 2..16.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- op_valid  in  1  operand pair offered
- op_ready  out  1  operand pair accepted when op_valid & op_ready
- op_a  in  16  operand A (DLFloat16)
- op_b  in  16  operand B (DLFloat16)
- pad_out  out  16  registered drive to MAC operand bus, bits [15:8]=uio_in, [7:0]=ui_in
- pad_in  in  8  MAC result byte (uo_out)
- res_valid  out  1  result word available
- res_ready  in  1  result consumer ready
- res_data  out  16  result word, FIFO head
- busy  out  1  in-flight ops or FIFO non-empty

Behaviour:
- Reset: clocked by clk, rst_n synchronous active-low. phase=0, pad_out=0, b_hold=0, hi_reg=0, tag shift register=0, inflight=0, FIFO empty, op_ready=0, res_valid=0, res_data=0, busy=0.
- phase: 1-bit, toggles every cycle after reset. The first cycle after release is phase 0.
- op_ready = (phase==1) & (inflight + fifo_count < FIFO_DEPTH). Credits make FIFO overflow impossible.
- Accept at the end of a phase-1 cycle:
  - pad_out <= op_a, so A is visible in the phase-0 slot.
  - b_hold <= op_b.
- At the end of the following phase-0 cycle: pad_out <= b_hold, so B is visible in the phase-1 slot.
- Idle slots: pad_out <= 16'h0000. No accept means both slots of that pair are 0.
- RX capture:
  - End of every phase-1 cycle: hi_reg <= pad_in.
  - End of every phase-0 cycle: word = {hi_reg, pad_in}, word complete.
- Tag pipeline: LAT_PAIRS-bit shift register.
  - Bit 0 loads 1 at an accept edge, otherwise 0.
  - The whole register shifts at every phase-0 edge.
  - When the MSB is 1 at a phase-0 edge, word is pushed to the FIFO and inflight decrements. Untagged words are discarded.
  - Accept at end of phase-1 cycle c means the matching word completes at edge c+1+2*(LAT_PAIRS-1).
- inflight: incremented on accept, decremented on tagged push. Both can happen at different edges only; no simultaneity, since accepts occur on phase-1 edges and pushes on phase-0 edges.
- FIFO:
  - res_data = head; res_valid = non-empty.
  - Pop on res_valid & res_ready.
  - Push and pop on the same edge is allowed at any occupancy, including full.
  - Output order is preserved.
- busy = (inflight != 0) | res_valid.
- Reset mid-operation drops all in-flight ops and FIFO contents. No result is emitted for pre-reset accepts.
- No arithmetic is performed on words. DLFloat16 format is sign[15], exp[14:9] (bias 31), mant[8:0]; 16'hFFFF is the NaN/Inf code.

Optional Feature:
- DLF_LINK_NAN_FLAG_EN defined:
  - Adds output res_nan (1 bit): high when res_valid and res_data==16'hFFFF.
  - Adds output nan_seen (1 bit): sticky, set on push of 16'hFFFF, cleared only by reset.
- Undefined: neither port exists; behaviour is otherwise identical.

Test Plan:
- Reset/idle: hold rst_n=0 for 3 cycles, then release → pad_out=0x0000, res_valid=0, busy=0; op_ready=0 in the first cycle and 1 in the second cycle.
- Single issue: op_a=0x3E00 (1.0), op_b=0x4000 (2.0) accepted in a phase-1 cycle → pad_out=0x3E00 next cycle, 0x4000 the cycle after, then 0x0000.
- Result reassembly, LAT_PAIRS=3: after the accept above, bench drives pad_in=0x40 in the phase-1 cycle and 0x00 in the phase-0 cycle ending at edge c+5 → res_valid=1 the next cycle with res_data=0x4000. Other bytes are ignored.
- Backpressure, FIFO_DEPTH=4, res_ready=0: offer 6 ops → exactly 4 accepted and op_ready stays 0. Pop one → op_ready returns at the next phase-1 cycle. FIFO order is preserved.
- Reset mid-flight: accept one op, pulse rst_n=0 for 1 cycle two cycles later → no res_valid for 20 cycles, pad_out=0, busy=0.
- NaN (DLF_LINK_NAN_FLAG_EN): tagged word bytes 0xFF,0xFF → res_data=0xFFFF, res_nan=1, nan_seen=1. nan_seen stays 1 after a following 0x3E00 result.
